// File: rtl/retire_selfcheck_monitor_pkg.sv
// Shared definitions for the retirement self-check monitor.
// Holds the program-memory size used for the default retire limit, the NOP
// encoding used as the default end-of-test sentinel, the FSM state type, the
// shadow-register bundle and the helper that forms the reported fail value.
package retire_selfcheck_monitor_pkg;

  localparam int unsigned PROGRAM_MEMORY_SIZE_WORDS = 1024;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    StRun,
    StPass,
    StFail,
    StTimeout
  } mon_state_e;

  typedef struct packed {
    logic [31:0] check;
    logic [31:0] testid;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
  } shadow_t;

  // A non-zero check register takes precedence; otherwise the failure came
  // from the compare pair and the XOR shows which bits disagree.
  function automatic logic [31:0] fail_syndrome(input shadow_t s);
    return (s.check != 32'd0) ? s.check : (s.cmp_a ^ s.cmp_b);
  endfunction

endpackage

// File: rtl/retire_watchdog.sv
// Retire watchdog: counts cycles since the last retire while enabled.
// Ports:
//   clk      clock
//   reset    synchronous, active-high
//   enable   count only while the monitor is running; frozen otherwise
//   clear    retire seen this cycle, restarts the count
//   expired  the count reaches MAX_CPI at the coming edge with no retire
module retire_watchdog
  import retire_selfcheck_monitor_pkg::*;
#(
  parameter int unsigned MAX_CPI = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CntW = $clog2(MAX_CPI + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      if (clear) begin
        cnt_d = '0;
      end else if (cnt_q != CntW'(MAX_CPI)) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // A retire in the cycle the limit would be reached wins over the timeout.
  assign expired = enable && !clear && (cnt_q == CntW'(MAX_CPI - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/retire_selfcheck_monitor.sv
// Retirement self-check monitor for the multi-cycle RISC-V core.
// Shadows the check, test-id and compare registers from the writeback port and
// checks them one cycle after each retire. The run ends in PASS (sentinel or
// retire limit), FAIL (check non-zero or compare mismatch) or TIMEOUT (no
// retire for MAX_CPI cycles); final states hold until reset.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   retire_valid/pc/instr         retirement pulse with PC and instruction word
//   wb_en/wb_addr/wb_data         register-file writeback
//   done/pass/fail/timeout        sticky status (done = any final state)
//   fail_test_id/fail_pc          test id and PC captured at FAIL or TIMEOUT
//   fail_value                    check value, or A XOR B for a compare failure
//   retired_count                 retires checked while running, saturating
module retire_selfcheck_monitor
  import retire_selfcheck_monitor_pkg::*;
#(
  parameter int unsigned CHECK_REG  = 31,
  parameter int unsigned TESTID_REG = 1,
  parameter int unsigned CMP_A_REG  = 2,
  parameter int unsigned CMP_B_REG  = 29,
  parameter bit          CMP_EN     = 1'b1,
  parameter logic [31:0] SENTINEL   = NOP_INSTR,
  parameter int unsigned MAX_INSTR  = PROGRAM_MEMORY_SIZE_WORDS - 1,
  parameter int unsigned MAX_CPI    = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             retire_valid,
  input  logic [31:0]      retire_pc,
  input  logic [31:0]      retire_instr,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [31:0]      wb_data,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [31:0]      fail_test_id,
  output logic [31:0]      fail_pc,
  output logic [31:0]      fail_value,
  output logic [CNT_W-1:0] retired_count
);

  mon_state_e       state_q, state_d;
  logic             chk_valid_q, chk_valid_d;
  logic [31:0]      chk_pc_q, chk_pc_d;
  logic [31:0]      chk_instr_q, chk_instr_d;
  shadow_t          shadow_q, shadow_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fail_test_id_q, fail_test_id_d;
  logic [31:0]      fail_pc_q, fail_pc_d;
  logic [31:0]      fail_value_q, fail_value_d;

  logic             running;
  logic             wb_hit;
  logic             check_err;
  logic             wd_expired;
  logic [CNT_W:0]   count_plus1;

  assign running     = (state_q == StRun);
  assign wb_hit      = running && wb_en && (wb_addr != 5'd0);
  assign check_err   = (shadow_q.check != 32'd0) ||
                       (CMP_EN && (shadow_q.cmp_a != shadow_q.cmp_b));
  // One bit wider so the limit compare is exact even at the saturation point.
  assign count_plus1 = {1'b0, count_q} + (CNT_W + 1)'(1);

  retire_watchdog #(
    .MAX_CPI (MAX_CPI)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .enable  (running),
    .clear   (retire_valid),
    .expired (wd_expired)
  );

  // Stage 0 capture and shadow update. chk_pc_q only moves on a retire, so it
  // doubles as the last retired PC reported on timeout.
  always_comb begin
    chk_valid_d = running && retire_valid;
    chk_pc_d    = chk_pc_q;
    chk_instr_d = chk_instr_q;
    if (chk_valid_d) begin
      chk_pc_d    = retire_pc;
      chk_instr_d = retire_instr;
    end

    shadow_d = shadow_q;
    if (wb_hit && (wb_addr == 5'(CHECK_REG)))  shadow_d.check  = wb_data;
    if (wb_hit && (wb_addr == 5'(TESTID_REG))) shadow_d.testid = wb_data;
    if (wb_hit && (wb_addr == 5'(CMP_A_REG)))  shadow_d.cmp_a  = wb_data;
    if (wb_hit && (wb_addr == 5'(CMP_B_REG)))  shadow_d.cmp_b  = wb_data;
  end

  // Stage 1: shadows already hold the retire-cycle writeback; writebacks in
  // this cycle land at the next edge and belong to the next instruction.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    fail_test_id_d = fail_test_id_q;
    fail_pc_d      = fail_pc_q;
    fail_value_d   = fail_value_q;

    unique case (state_q)
      StRun: begin
        if (chk_valid_q) begin
          if (!(&count_q)) begin
            count_d = count_plus1[CNT_W-1:0];
          end
          if (check_err) begin
            state_d        = StFail;
            fail_test_id_d = shadow_q.testid;
            fail_pc_d      = chk_pc_q;
            fail_value_d   = fail_syndrome(shadow_q);
          end else if (chk_instr_q == SENTINEL) begin
            state_d = StPass;
          end else if (count_plus1 == (CNT_W + 1)'(MAX_INSTR)) begin
            state_d = StPass;
          end
        end else if (wd_expired) begin
          state_d        = StTimeout;
          fail_test_id_d = shadow_q.testid;
          fail_pc_d      = chk_pc_q;
        end
      end
      StPass, StFail, StTimeout: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StRun;
      chk_valid_q    <= 1'b0;
      chk_pc_q       <= '0;
      chk_instr_q    <= '0;
      shadow_q       <= '0;
      count_q        <= '0;
      fail_test_id_q <= '0;
      fail_pc_q      <= '0;
      fail_value_q   <= '0;
    end else begin
      state_q        <= state_d;
      chk_valid_q    <= chk_valid_d;
      chk_pc_q       <= chk_pc_d;
      chk_instr_q    <= chk_instr_d;
      shadow_q       <= shadow_d;
      count_q        <= count_d;
      fail_test_id_q <= fail_test_id_d;
      fail_pc_q      <= fail_pc_d;
      fail_value_q   <= fail_value_d;
    end
  end

  assign pass          = (state_q == StPass);
  assign fail          = (state_q == StFail);
  assign timeout       = (state_q == StTimeout);
  assign done          = (state_q != StRun);
  assign fail_test_id  = fail_test_id_q;
  assign fail_pc       = fail_pc_q;
  assign fail_value    = fail_value_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_retire_selfcheck_monitor.sv
// Bench for retire_selfcheck_monitor. Two instances share the stimulus:
// dut0 uses defaults, dut1 has CMP_EN=0 and MAX_INSTR=3. A snapshot-based
// model (full register file, per-retire verdict records, cycle timestamps for
// the watchdog) predicts every output each cycle; literal checks pin the
// model on the listed scenarios, then a randomized phase runs.
module tb_retire_selfcheck_monitor;

  localparam int          MaxCpi = 16;
  localparam logic [31:0] Nop    = 32'h0000_0013;
  localparam logic [31:0] Addi   = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        reset, retire_valid, wb_en;
  logic [31:0] retire_pc, retire_instr, wb_data;
  logic [4:0]  wb_addr;

  logic [1:0]  done, pass, fail, timeout;
  logic [31:0] fail_test_id [2];
  logic [31:0] fail_pc      [2];
  logic [31:0] fail_value   [2];
  logic [15:0] retired_count[2];

  always #5 clk = ~clk;

  retire_selfcheck_monitor u_dut0 (
    .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_instr(retire_instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .done(done[0]), .pass(pass[0]), .fail(fail[0]), .timeout(timeout[0]),
    .fail_test_id(fail_test_id[0]), .fail_pc(fail_pc[0]), .fail_value(fail_value[0]),
    .retired_count(retired_count[0])
  );

  retire_selfcheck_monitor #(.CMP_EN(1'b0), .MAX_INSTR(3)) u_dut1 (
    .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_instr(retire_instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .done(done[1]), .pass(pass[1]), .fail(fail[1]), .timeout(timeout[1]),
    .fail_test_id(fail_test_id[1]), .fail_pc(fail_pc[1]), .fail_value(fail_value[1]),
    .retired_count(retired_count[1])
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] chk;
    logic [31:0] tid;
    logic [31:0] a;
    logic [31:0] b;
  } rec_t;

  int unsigned cfg_max_instr [2] = '{1023, 3};
  bit          cfg_cmp_en    [2] = '{1'b1, 1'b0};

  int          m_status  [2];  // 0 run, 1 pass, 2 fail, 3 timeout
  logic [31:0] m_tid     [2];
  logic [31:0] m_pc      [2];
  logic [31:0] m_val     [2];
  int unsigned m_count   [2];
  logic [31:0] m_regs    [2][32];
  logic [31:0] m_last_pc [2];
  longint      m_last_evt[2];
  rec_t        pend      [2];
  bit          pend_v    [2];

  longint      cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          quiet = 0;
  logic [4:0]  addr_tab [6] = '{5'd0, 5'd1, 5'd2, 5'd29, 5'd31, 5'd5};

  function automatic void model_step(input int d, input bit rst, input bit rv,
      input logic [31:0] pc, input logic [31:0] instr, input bit wen,
      input logic [4:0] wa, input logic [31:0] wd);
    bit running;
    if (rst) begin
      m_status[d] = 0; m_tid[d] = 0; m_pc[d] = 0; m_val[d] = 0; m_count[d] = 0;
      for (int r = 0; r < 32; r++) m_regs[d][r] = 32'd0;
      m_last_pc[d] = 0; m_last_evt[d] = cyc; pend_v[d] = 1'b0;
      return;
    end
    running = (m_status[d] == 0);
    // Verdict of last cycle's retire, taken from its snapshot.
    if (running && pend_v[d]) begin
      int unsigned prev;
      prev = m_count[d];
      if (m_count[d] != 32'hFFFF) m_count[d] = m_count[d] + 1;
      if (pend[d].chk != 0 || (cfg_cmp_en[d] && pend[d].a != pend[d].b)) begin
        m_status[d] = 2;
        m_tid[d]    = pend[d].tid;
        m_pc[d]     = pend[d].pc;
        m_val[d]    = (pend[d].chk != 0) ? pend[d].chk : (pend[d].a ^ pend[d].b);
      end else if (pend[d].instr == Nop) begin
        m_status[d] = 1;
      end else if (prev + 1 == cfg_max_instr[d]) begin
        m_status[d] = 1;
      end
    end else if (running && !rv && (cyc - m_last_evt[d] == MaxCpi)) begin
      m_status[d] = 3;
      m_tid[d]    = m_regs[d][1];
      m_pc[d]     = m_last_pc[d];
    end
    pend_v[d] = 1'b0;
    if (running) begin
      if (wen && wa != 0) m_regs[d][wa] = wd;
      if (rv) begin
        pend[d] = '{pc: pc, instr: instr, chk: m_regs[d][31], tid: m_regs[d][1],
                    a: m_regs[d][2], b: m_regs[d][29]};
        pend_v[d]     = 1'b1;
        m_last_pc[d]  = pc;
        m_last_evt[d] = cyc;
      end
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", name, d, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      chk("done",    d, 32'(done[d]),    32'(m_status[d] != 0));
      chk("pass",    d, 32'(pass[d]),    32'(m_status[d] == 1));
      chk("fail",    d, 32'(fail[d]),    32'(m_status[d] == 2));
      chk("timeout", d, 32'(timeout[d]), 32'(m_status[d] == 3));
      chk("fail_test_id",  d, fail_test_id[d],       m_tid[d]);
      chk("fail_pc",       d, fail_pc[d],            m_pc[d]);
      chk("fail_value",    d, fail_value[d],         m_val[d]);
      chk("retired_count", d, 32'(retired_count[d]), m_count[d]);
    end
  endtask

  task automatic step(input bit rst, input bit rv, input logic [31:0] pc,
      input logic [31:0] instr, input bit wen, input logic [4:0] wa, input logic [31:0] wd);
    reset = rst; retire_valid = rv; retire_pc = pc; retire_instr = instr;
    wb_en = wen; wb_addr = wa; wb_data = wd;
    for (int d = 0; d < 2; d++) model_step(d, rst, rv, pc, instr, wen, wa, wd);
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask
  task automatic wb(input logic [4:0] wa, input logic [31:0] wd);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, wa, wd);
  endtask
  task automatic retire(input logic [31:0] pc, input logic [31:0] instr);
    step(1'b0, 1'b1, pc, instr, 1'b0, 5'd0, 32'd0);
  endtask
  task automatic retire_wb(input logic [31:0] pc, input logic [31:0] instr,
                           input logic [4:0] wa, input logic [31:0] wd);
    step(1'b0, 1'b1, pc, instr, 1'b1, wa, wd);
  endtask

  initial begin
    logic        r_rst, r_rv, r_wen;
    logic [4:0]  r_wa;
    logic [31:0] r_wd, r_pc, r_instr;

    // Reset state
    do_reset();
    chk("rst_done",  0, 32'(done[0]), 32'd0);
    chk("rst_count", 0, 32'(retired_count[0]), 32'd0);

    // Sentinel PASS after five retires; dut1 passes on its third retire
    wb(5'd31, 32'd0);
    for (int i = 1; i <= 5; i++) retire_wb(32'((i - 1) * 4), Addi, 5'd1, 32'(i));
    retire(32'h14, Nop);
    chk("sent_latency", 0, 32'(pass[0]), 32'd0);
    idle();
    chk("sent_pass",  0, 32'(pass[0]), 32'd1);
    chk("sent_count", 0, 32'(retired_count[0]), 32'd6);
    chk("lim_pass",   1, 32'(pass[1]), 32'd1);
    chk("lim_count",  1, 32'(retired_count[1]), 32'd3);

    // Check register non-zero in the retire cycle
    do_reset();
    wb(5'd1, 32'd7);
    retire_wb(32'h20, Addi, 5'd31, 32'h4);
    chk("chk_latency", 0, 32'(fail[0]), 32'd0);
    idle();
    chk("chk_fail", 0, 32'(fail[0]), 32'd1);
    chk("chk_tid",  0, fail_test_id[0], 32'd7);
    chk("chk_pc",   0, fail_pc[0], 32'h20);
    chk("chk_val",  0, fail_value[0], 32'h4);
    chk("chk_fail", 1, 32'(fail[1]), 32'd1);

    // Compare pair mismatch, masked on dut1
    do_reset();
    wb(5'd2, 32'd5);
    wb(5'd29, 32'd6);
    retire_wb(32'h10, Addi, 5'd31, 32'd0);
    idle();
    chk("cmp_fail", 0, 32'(fail[0]), 32'd1);
    chk("cmp_val",  0, fail_value[0], 32'h3);
    chk("cmp_pc",   0, fail_pc[0], 32'h10);
    chk("cmp_off_fail", 1, 32'(fail[1]), 32'd0);
    chk("cmp_off_done", 1, 32'(done[1]), 32'd0);

    // Watchdog expiry
    do_reset();
    retire(32'h8, Addi);
    repeat (15) idle();
    chk("wd_early", 0, 32'(timeout[0]), 32'd0);
    idle();
    chk("wd_timeout", 0, 32'(timeout[0]), 32'd1);
    chk("wd_pc",      0, fail_pc[0], 32'h8);
    chk("wd_fail",    0, 32'(fail[0]), 32'd0);

    // Retire exactly at the limit wins
    do_reset();
    retire(32'h8, Addi);
    repeat (15) idle();
    retire(32'hC, Addi);
    chk("wd_race", 0, 32'(timeout[0]), 32'd0);
    idle();
    chk("wd_race_after", 0, 32'(done[0]), 32'd0);

    // Reset mid-run with a concurrent retire
    do_reset();
    retire(32'h0, Addi);
    retire(32'h4, Addi);
    idle();
    chk("mid_count2", 0, 32'(retired_count[0]), 32'd2);
    step(1'b1, 1'b1, 32'h8, Addi, 1'b0, 5'd0, 32'd0);
    chk("mid_rst_count", 0, 32'(retired_count[0]), 32'd0);
    chk("mid_rst_done",  0, 32'(done[0]), 32'd0);
    idle();
    chk("mid_rst_drop",  0, 32'(retired_count[0]), 32'd0);

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      r_rst = ($urandom_range(0, 79) == 0) || ((&done) && ($urandom_range(0, 3) == 0));
      if (quiet > 0) begin
        quiet--;
        r_rv = 1'b0;
      end else begin
        if ($urandom_range(0, 99) == 0) quiet = int'($urandom_range(12, 20));
        r_rv = ($urandom_range(0, 99) < 45);
      end
      r_pc    = $urandom & 32'hFFFF_FFFC;
      r_instr = ($urandom_range(0, 11) == 0) ? Nop : ($urandom | 32'h0000_0100);
      r_wen   = ($urandom_range(0, 1) == 1);
      r_wa    = addr_tab[$urandom_range(0, 5)];
      case (r_wa)
        5'd31:        r_wd = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
        5'd2, 5'd29:  r_wd = 32'($urandom_range(0, 2));
        default:      r_wd = $urandom;
      endcase
      step(r_rst, r_rv, r_pc, r_instr, r_wen, r_wa, r_wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/retire_selfcheck_monitor.md
# retire_selfcheck_monitor

Synthesizable self-check monitor for the multi-cycle RISC-V core. It observes instruction retirement and register-file writeback, and shadows a configurable check register, test-id register and pair of compare registers. It flags the first retired instruction after which the check register is non-zero, or after which the two compare registers differ. Final status is reported as PASS, FAIL or TIMEOUT. It sits beside `cpu` inside `SoC` and replaces per-instruction polling from benches, so FPGA builds self-report as well.

## Interface
- `CHECK_REG`, 31: register that must read zero after every retire
- `TESTID_REG`, 1: register holding the current sub-test number
- `CMP_A_REG`, 2 / `CMP_B_REG`, 29: registers that must be equal after every retire; `CMP_EN`, 1 enables this check
- `SENTINEL`, 32'h00000013: retiring this instruction ends the run with PASS
- `MAX_INSTR`, `PROGRAM_MEMORY_SIZE_WORDS-1`: retire count that ends the run with PASS
- `MAX_CPI`, 16: maximum cycles between retires before TIMEOUT
- `CNT_W`, 16: width of the retire counter
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `retire_valid`  in  1  one-cycle pulse, instruction completed
- `retire_pc`  in  32  PC of the retiring instruction
- `retire_instr`  in  32  retiring instruction word
- `wb_en`  in  1  register-file write strobe
- `wb_addr`  in  5  destination register
- `wb_data`  in  32  write data
- `done`  out  1  run finished (sticky)
- `pass`  out  1  finished without error (sticky)
- `fail`  out  1  check failure (sticky)
- `timeout`  out  1  watchdog expired (sticky)
- `fail_test_id`  out  32  TESTID shadow at the failure
- `fail_pc`  out  32  PC of the failing instruction
- `fail_value`  out  32  CHECK shadow at failure, or A XOR B for a compare failure
- `retired_count`  out  `CNT_W`  instructions retired, saturating

## Operation
- Shadow registers for CHECK, TESTID, CMP_A and CMP_B:
  - Updated on `wb_en` when `wb_addr` matches the register's index.
  - `wb_addr==0` is ignored.
  - All shadows reset to 0.
- Two-stage pipeline:
  - Stage 0 latches `retire_valid`, `retire_pc` and `retire_instr` into `chk_*`.
  - Stage 1 evaluates the checks on the shadows, which already include any writeback from the retire cycle.
- FSM states: RUN → {PASS, FAIL, TIMEOUT}. The three final states are absorbing until `reset`.
- RUN, when `chk_valid` is high, resolved in this priority order:
  1. CHECK shadow ≠ 0, or (`CMP_EN` and A ≠ B): go to FAIL and latch the `fail_*` outputs.
  2. `chk_instr==SENTINEL`: go to PASS.
  3. `retired_count+1 == MAX_INSTR`: go to PASS.
- Checks are evaluated before the sentinel, so a failing sentinel instruction reports FAIL.
- `retired_count` increments on each `chk_valid` in RUN and saturates at all-ones.
- Watchdog:
  - Counts cycles in RUN since the last `retire_valid`, and clears on `retire_valid`.
  - Reaching `MAX_CPI` goes to TIMEOUT, with `fail_pc` = last retired PC and `fail_test_id` = current TESTID shadow.
  - If `retire_valid` arrives in the same cycle the counter reaches `MAX_CPI`, the retire wins and no timeout is raised.
- In final states, `retire_valid` and `wb_en` are ignored, and shadows and counters freeze.

## Timing
- Every output resets to 0. The FSM resets to RUN and the watchdog counter to 0.
- Latency: a failure is visible on `fail`/`done` 2 cycles after the `retire_valid` edge.
- Writebacks landing in the cycle after retire belong to the next instruction's check, not this one.
- `reset` in the middle of a run clears everything on the next edge. Any `retire_valid` in that same cycle is discarded.
- `done` = `pass` | `fail` | `timeout`. Exactly one of the three is ever set.

## Structure
- Shared `parameters.vh` holds `PROGRAM_MEMORY_SIZE_WORDS` and a new `` `NOP_INSTR `` constant (32'h00000013) used as the default `SENTINEL`.
- One sub-module, `retire_watchdog`: cycle counter with clear and `MAX_CPI` compare, emitting `expired`.

## Test plan
- Writes x31=0, x1=1..5, five retires, then sentinel 0x00000013 retired → `pass`=1 and `retired_count`=6, at 2 cycles after the sentinel retire.
- x1=7, x31=0x4 written in the same cycle as a retire at PC 0x20 → `fail`=1, `fail_test_id`=7, `fail_pc`=0x20, `fail_value`=0x4.
- x2=5, x29=6, x31=0, retire at PC 0x10 → `fail`=1, `fail_value`=0x3. Same stimulus with `CMP_EN`=0 → no fail.
- No retire for 16 cycles after a retire at PC 0x8 → `timeout`=1, `fail_pc`=0x8. Retire exactly at cycle 16 → no timeout.
- `MAX_INSTR`=3 with non-sentinel instructions → PASS after the third retire. Further retires leave the count at 3.
- Assert `reset` during RUN with `retired_count`=2, concurrent with `retire_valid` → all outputs 0 and the count remains 0.
